mips_mem_responder: RTL

- Memory-side responder for the multicycle MIPS control FSM; answers that FSM's IR_write / Mem_write / lorD_mux strobes.
- Holds a unified instruction/data word memory, the Instruction Register (IR) and the Memory Data Register (MDR).
- Presents op/Funct back to the control FSM.
- Sits between the PC/ALU-out registers of the datapath and the control FSM; the testbench preloads programs through a side load port.

---
 rtl/mips_mem_responder_if.sv | 34 +++
 rtl/mips_mem_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder_if.sv
// Bus between the multicycle MIPS control FSM/datapath and the memory responder.
// The master drives addresses, strobes and preload data; the slave returns IR/MDR and status.
interface mips_mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic [31:0]       PC_addr;
    logic [31:0]       ALU_out;
    logic              lorD_mux;
    logic              IR_write;
    logic              Mem_write;
    logic [31:0]       wdata;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic [31:0]       instr;
    logic [5:0]        op;
    logic [5:0]        Funct;
    logic [31:0]       mdr;
    logic              busy;
    logic              mem_ready;
    logic              addr_err;

    modport master (
        output PC_addr, ALU_out, lorD_mux, IR_write, Mem_write, wdata,
               load_en, load_addr, load_data,
        input  instr, op, Funct, mdr, busy, mem_ready, addr_err
    );

    modport slave (
        input  PC_addr, ALU_out, lorD_mux, IR_write, Mem_write, wdata,
               load_en, load_addr, load_data,
        output instr, op, Funct, mdr, busy, mem_ready, addr_err
    );
endinterface

// File: rtl/mips_mem_responder.sv
// Memory responder for the multicycle MIPS core: unified word memory plus IR and MDR,
// driven by rising edges of the control FSM's IR_write / Mem_write strobes.
module mips_mem_responder #(
    parameter int ADDR_W = 8
) (
    input  logic                 clock,
    input  logic                 rst,
    mips_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

    state_t state, state_nxt;

    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       rdata;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              lord_q;
    logic [31:0]       instr_q;
    logic [31:0]       mdr_q;
    logic              prev_ir;
    logic              prev_mw;
    logic              ready_q;
    logic              err_q;

    logic              ir_rise;
    logic              mw_rise;
    logic              addr_bad;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       sel_addr;

    logic              latch_wr;
    logic              latch_rd;
    logic              mem_load;
    logic              mem_store;
    logic              rd_fetch;
    logic              done;

    assign ir_rise  = bus.IR_write  && !prev_ir;
    assign mw_rise  = bus.Mem_write && !prev_mw;
    assign sel_addr = bus.lorD_mux ? bus.ALU_out : bus.PC_addr;

    // Out-of-range addresses are flagged rather than wrapped into the array.
    assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
    assign word_idx = addr_q[ADDR_W+1:2];

    always_ff @(posedge clock or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.load_en)
                    state_nxt = IDLE;
                else if (mw_rise)
                    state_nxt = WR;
                else if (ir_rise)
                    state_nxt = RD_ADDR;
            end
            RD_ADDR: state_nxt = RD_DATA;
            RD_DATA: state_nxt = IDLE;
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Preload wins over strobes in IDLE, and a write wins over a simultaneous read.
    always_comb begin
        latch_wr  = 1'b0;
        latch_rd  = 1'b0;
        mem_load  = 1'b0;
        mem_store = 1'b0;
        rd_fetch  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                mem_load = bus.load_en && rst;
                latch_wr = !bus.load_en && mw_rise;
                latch_rd = !bus.load_en && !mw_rise && ir_rise;
            end
            RD_ADDR: rd_fetch = 1'b1;
            RD_DATA: done = 1'b1;
            WR: begin
                mem_store = !addr_bad;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            prev_ir <= 1'b0;
            prev_mw <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lord_q  <= 1'b0;
            instr_q <= '0;
            mdr_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev_ir <= bus.IR_write;
            prev_mw <= bus.Mem_write;
            if (latch_wr) begin
                addr_q  <= sel_addr;
                wdata_q <= bus.wdata;
                lord_q  <= bus.lorD_mux;
            end else if (latch_rd) begin
                addr_q  <= sel_addr;
                lord_q  <= bus.lorD_mux;
            end
            if (state == RD_DATA) begin
                if (lord_q)
                    mdr_q   <= rdata;
                else
                    instr_q <= rdata;
            end
            ready_q <= done;
            err_q   <= done && addr_bad;
        end
    end

    // The array itself is never reset so preloaded programs survive a reset.
    always_ff @(posedge clock) begin
        if (mem_load)
            mem[bus.load_addr] <= bus.load_data;
        else if (mem_store)
            mem[word_idx] <= wdata_q;
        if (rd_fetch)
            rdata <= addr_bad ? 32'h0 : mem[word_idx];
    end

    assign bus.instr     = instr_q;
    assign bus.op        = instr_q[31:26];
    assign bus.Funct     = instr_q[5:0];
    assign bus.mdr       = mdr_q;
    assign bus.busy      = (state != IDLE);
    assign bus.mem_ready = ready_q;
    assign bus.addr_err  = err_q;
endmodule
